// File: rtl/process_pkg.sv
// Shared definitions for the process register-file unit and its command issuer:
// opcode encoding, issuer FSM state encoding and default operand widths.
package process_pkg;

  localparam int PKG_ADDR_W = 5;
  localparam int PKG_DATA_W = 16;

  localparam logic [2:0] OP_NOP_WR   = 3'b000;
  localparam logic [2:0] OP_RD1      = 3'b001;
  localparam logic [2:0] OP_RD12     = 3'b010;
  localparam logic [2:0] OP_WR_RD1   = 3'b011;
  localparam logic [2:0] OP_WR_RD12  = 3'b100;
  localparam logic [2:0] OP_RD1_WR   = 3'b101;
  localparam logic [2:0] OP_RD1_ALT  = 3'b110;
  localparam logic [2:0] OP_WR_RD2   = 3'b111;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_CAPTURE = 2'd3;

endpackage

// File: rtl/process_issuer_cmd_fifo.sv
// Synchronous command FIFO: power-of-two depth, naturally wrapping pointers,
// count one bit wider than the pointers so full and empty are distinct.
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries no reset; only pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/process_issuer.sv
// Command issuer for the process unit: FIFO-buffered commands, held operands, done-edge capture.
// Optional WAIT watchdog compiled in with PROCESS_ISSUER_WATCHDOG_EN.
module process_issuer
  import process_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = PKG_ADDR_W,
  parameter int DATA_W  = PKG_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [ADDR_W-1:0]        cmd_adr1,
  input  logic [ADDR_W-1:0]        cmd_adr2,
  input  logic [ADDR_W-1:0]        cmd_wadr,
  input  logic signed [DATA_W-1:0] cmd_data,
  output logic [2:0]               instruction,
  output logic [ADDR_W-1:0]        input_adr1,
  output logic [ADDR_W-1:0]        input_adr2,
  output logic [ADDR_W-1:0]        write_adr,
  output logic signed [DATA_W-1:0] data,
  input  logic                     done,
  input  logic signed [DATA_W-1:0] read1,
  input  logic signed [DATA_W-1:0] read2,
  output logic                     res_valid,
  output logic [2:0]               res_op,
  output logic signed [DATA_W-1:0] res_val1,
  output logic signed [DATA_W-1:0] res_val2,
  output logic                     busy,
  output logic                     err_timeout
);

  localparam int CMD_W = 3 + 3 * ADDR_W + DATA_W;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("process_issuer: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  typedef struct packed {
    logic [2:0]        op;
    logic [ADDR_W-1:0] adr1;
    logic [ADDR_W-1:0] adr2;
    logic [ADDR_W-1:0] wadr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  logic [CMD_W-1:0]         fifo_wdata;
  logic [CMD_W-1:0]         fifo_rdata;
  logic                     fifo_full;
  logic                     fifo_empty;
  cmd_t                     head;
  logic [1:0]               state_q, state_d;
  logic                     pop;
  logic                     capture;
  logic                     done_q;
  logic                     done_edge;
  logic                     res_valid_q;
  logic [2:0]               instr_q, res_op_q;
  logic [ADDR_W-1:0]        adr1_q, adr2_q, wadr_q;
  logic signed [DATA_W-1:0] data_q, res_val1_q, res_val2_q;
`ifdef PROCESS_ISSUER_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0]          wd_cnt_q;
  logic                     wd_expired;
  logic                     err_q;
`endif

  assign fifo_wdata = {cmd_op, cmd_adr1, cmd_adr2, cmd_wadr, cmd_data};
  assign head       = fifo_rdata;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid),
    .pop_i   (pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A done already high on WAIT entry is not a completion: only a fresh rise counts.
  assign done_edge = done && !done_q;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
`ifdef PROCESS_ISSUER_WATCHDOG_EN
    wd_expired = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (done_edge) begin
          capture = 1'b1;
          state_d = ST_CAPTURE;
        end
`ifdef PROCESS_ISSUER_WATCHDOG_EN
        else if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
          wd_expired = 1'b1;
          state_d    = ST_IDLE;
        end
`endif
      end
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      instr_q     <= OP_NOP_WR;
      adr1_q      <= '0;
      adr2_q      <= '0;
      wadr_q      <= '0;
      data_q      <= '0;
      res_op_q    <= '0;
      res_val1_q  <= '0;
      res_val2_q  <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done;
      res_valid_q <= (state_q == ST_CAPTURE);
      if (pop) begin
        instr_q <= head.op;
        adr1_q  <= head.adr1;
        adr2_q  <= head.adr2;
        wadr_q  <= head.wadr;
        data_q  <= head.data;
      end
      if (capture) begin
        res_op_q   <= instr_q;
        res_val1_q <= read1;
        res_val2_q <= read2;
      end
    end
  end

`ifdef PROCESS_ISSUER_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == ST_ISSUE)     wd_cnt_q <= '0;
      else if (state_q == ST_WAIT) wd_cnt_q <= wd_cnt_q + 1'b1;
      if (wd_expired) err_q <= 1'b1;
    end
  end
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign cmd_ready   = !fifo_full;
  assign busy        = (state_q != ST_IDLE) || !fifo_empty;
  assign instruction = instr_q;
  assign input_adr1  = adr1_q;
  assign input_adr2  = adr2_q;
  assign write_adr   = wadr_q;
  assign data        = data_q;
  assign res_valid   = res_valid_q;
  assign res_op      = res_op_q;
  assign res_val1    = res_val1_q;
  assign res_val2    = res_val2_q;

endmodule

// File: tb/tb_process_issuer.sv
// Scoreboard bench for process_issuer with a behavioural stand-in for the process unit.
module tb_process_issuer;

  localparam int DEPTH   = 8;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst, cmd_valid, cmd_ready, done, res_valid, busy, err_timeout;
  logic [2:0]               cmd_op, instruction, res_op;
  logic [ADDR_W-1:0]        cmd_adr1, cmd_adr2, cmd_wadr, input_adr1, input_adr2, write_adr;
  logic signed [DATA_W-1:0] cmd_data, data, read1, read2, res_val1, res_val2;

  process_issuer #(
    .DEPTH (DEPTH), .ADDR_W (ADDR_W), .DATA_W (DATA_W), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk), .rst (rst),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_op (cmd_op),
    .cmd_adr1 (cmd_adr1), .cmd_adr2 (cmd_adr2), .cmd_wadr (cmd_wadr), .cmd_data (cmd_data),
    .instruction (instruction), .input_adr1 (input_adr1), .input_adr2 (input_adr2),
    .write_adr (write_adr), .data (data),
    .done (done), .read1 (read1), .read2 (read2),
    .res_valid (res_valid), .res_op (res_op), .res_val1 (res_val1), .res_val2 (res_val2),
    .busy (busy), .err_timeout (err_timeout)
  );

  typedef struct {
    logic [2:0]               op;
    logic [ADDR_W-1:0]        a1, a2, wa;
    logic signed [DATA_W-1:0] d, r1, r2;
  } exp_t;

  exp_t                     sb[$];
  logic signed [DATA_W-1:0] rf [32];
  logic [2:0]               obs_op[$];
  logic signed [DATA_W-1:0] obs_v1[$], obs_v2[$];
  int  n_chk, n_fail, cyc_n, done_cyc, mdl_cnt, mdl_lat;
  bit  model_en;

  // One clock step: observe results against the scoreboard, then let the process model react.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    cyc_n++;
    if (res_valid) begin
      obs_op.push_back(res_op);
      obs_v1.push_back(res_val1);
      obs_v2.push_back(res_val2);
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: res_valid=1 op=%0b, expected no result", res_op);
      end else begin
        e = sb.pop_front();
        n_chk++;
        if (res_op !== e.op) begin
          n_fail++;
          $display("FAIL res_op: got %0b, expected %0b", res_op, e.op);
        end
        n_chk++;
        if (res_val1 !== e.r1) begin
          n_fail++;
          $display("FAIL res_val1: got %0d, expected %0d", res_val1, e.r1);
        end
        n_chk++;
        if (res_val2 !== e.r2) begin
          n_fail++;
          $display("FAIL res_val2: got %0d, expected %0d", res_val2, e.r2);
        end
        n_chk++;
        if (cyc_n - done_cyc !== 2) begin
          n_fail++;
          $display("FAIL done_to_res_latency: got %0d cycles, expected 2", cyc_n - done_cyc);
        end
      end
      if (model_en) begin
        done    = 1'b0;
        mdl_cnt = 0;
      end
    end else if (model_en && sb.size() > 0) begin
      n_chk++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_while_pending: got %0b, expected 1", busy);
      end
      if (!done) begin
        mdl_cnt++;
        if (mdl_cnt >= 3) begin
          n_chk++;
          if ({instruction, input_adr1, input_adr2, write_adr, data} !==
              {sb[0].op, sb[0].a1, sb[0].a2, sb[0].wa, sb[0].d}) begin
            n_fail++;
            $display("FAIL operands_held: got op=%0b a1=%0d a2=%0d wa=%0d d=%0d, expected op=%0b a1=%0d a2=%0d wa=%0d d=%0d",
                     instruction, input_adr1, input_adr2, write_adr, data,
                     sb[0].op, sb[0].a1, sb[0].a2, sb[0].wa, sb[0].d);
          end
        end
        if (mdl_cnt >= mdl_lat) begin
          done     = 1'b1;
          read1    = sb[0].r1;
          read2    = sb[0].r2;
          done_cyc = cyc_n;
        end
      end
    end
  endtask

  task automatic push(input logic [2:0] op, input logic [ADDR_W-1:0] a1, a2, wa,
                      input logic signed [DATA_W-1:0] d, output bit acc);
    exp_t e;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_adr1  = a1;
    cmd_adr2  = a2;
    cmd_wadr  = wa;
    cmd_data  = d;
    acc       = cmd_ready;
    if (acc) begin
      e.op = op; e.a1 = a1; e.a2 = a2; e.wa = wa; e.d = d;
      e.r1 = rf[a1];
      e.r2 = rf[a2];
      rf[wa] = d;
      sb.push_back(e);
    end
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while (sb.size() > 0 && i < budget) begin
      cyc();
      i++;
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results still pending after %0d cycles, expected 0", sb.size(), budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    n_chk++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ready=%0b busy=%0b err=%0b, expected 1 0 0", cmd_ready, busy, err_timeout);
    end
    n_chk++;
    if ({instruction, input_adr1, input_adr2, write_adr, data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got op=%0b a1=%0d a2=%0d wa=%0d d=%0d, expected all 0",
               instruction, input_adr1, input_adr2, write_adr, data);
    end
    n_chk++;
    if ({res_valid, res_op, res_val1, res_val2} !== '0) begin
      n_fail++;
      $display("FAIL reset_result: got v=%0b op=%0b v1=%0d v2=%0d, expected all 0", res_valid, res_op, res_val1, res_val2);
    end
  endtask

  task automatic test_single();
    bit acc;
    model_en = 1'b1;
    mdl_lat  = 5;
    mdl_cnt  = 0;
    push(3'b000, 5'd0, 5'd0, 5'd1, 16'sd17, acc);
    n_chk++;
    if (acc !== 1'b1 || write_adr !== 5'd0) begin
      n_fail++;
      $display("FAIL single_not_yet_issued: got acc=%0b wadr=%0d, expected 1 0", acc, write_adr);
    end
    cyc();
    n_chk++;
    if (instruction !== 3'b000 || write_adr !== 5'd1 || data !== 16'sd17) begin
      n_fail++;
      $display("FAIL single_issue_latency: got op=%0b wadr=%0d d=%0d, expected 000 1 17", instruction, write_adr, data);
    end
    drain(30);
  endtask

  task automatic test_back_to_back();
    bit acc;
    int base;
    base = obs_op.size();
    push(3'b011, 5'd1, 5'd0, 5'd2, -16'sd9, acc);
    push(3'b100, 5'd1, 5'd2, 5'd3, 16'sd65, acc);
    push(3'b010, 5'd2, 5'd3, 5'd0, 16'sd0, acc);
    drain(60);
    n_chk++;
    if (obs_op.size() !== base + 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results, expected 3", obs_op.size() - base);
    end else begin
      n_chk++;
      if ({obs_op[base], obs_op[base+1], obs_op[base+2]} !== {3'b011, 3'b100, 3'b010}) begin
        n_fail++;
        $display("FAIL b2b_order: got %0b %0b %0b, expected 011 100 010", obs_op[base], obs_op[base+1], obs_op[base+2]);
      end
      n_chk++;
      if (obs_v1[base] !== 16'sd17 || obs_v2[base+1] !== -16'sd9 ||
          obs_v1[base+2] !== -16'sd9 || obs_v2[base+2] !== 16'sd65) begin
        n_fail++;
        $display("FAIL b2b_values: got %0d %0d %0d %0d, expected 17 -9 -9 65",
                 obs_v1[base], obs_v2[base+1], obs_v1[base+2], obs_v2[base+2]);
      end
    end
  endtask

  task automatic test_long_op();
    bit acc;
    push(3'b000, 5'd0, 5'd0, 5'd4, 16'sd3, acc);
    drain(30);
    mdl_lat = 200;
    push(3'b111, 5'd0, 5'd4, 5'd5, 16'sd7, acc);
    drain(400);
    mdl_lat = 5;
    n_chk++;
    if (obs_op[$] !== 3'b111 || obs_v2[$] !== 16'sd3) begin
      n_fail++;
      $display("FAIL long_op_result: got op=%0b v2=%0d, expected 111 3", obs_op[$], obs_v2[$]);
    end
  endtask

  task automatic test_fifo_full();
    bit acc;
    int n_acc, base;
    model_en = 1'b0;
    done     = 1'b0;
    n_acc    = 0;
    base     = obs_op.size();
    for (int i = 0; i < 10; i++) begin
      push(3'(i % 8), 5'(i), 5'(i + 1), 5'(8 + i), 16'(100 + i), acc);
      if (acc) n_acc++;
    end
    n_chk++;
    if (n_acc !== 9 || acc !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo_full_accept: got %0d accepted (last=%0b), expected 9 accepted and last rejected", n_acc, acc);
    end
    n_chk++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo_full_ready: got %0b, expected 0", cmd_ready);
    end
    model_en = 1'b1;
    mdl_cnt  = 0;
    drain(200);
    n_chk++;
    if (obs_op.size() !== base + 9) begin
      n_fail++;
      $display("FAIL fifo_full_count: got %0d results, expected 9", obs_op.size() - base);
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_chk++;
        if (obs_op[base + i] !== 3'(i % 8)) begin
          n_fail++;
          $display("FAIL fifo_full_order[%0d]: got %0b, expected %0b", i, obs_op[base + i], 3'(i % 8));
        end
      end
    end
  endtask

  task automatic test_stale_done();
    bit acc;
    model_en = 1'b0;
    done     = 1'b1;
    push(3'b110, 5'd1, 5'd2, 5'd6, -16'sd5, acc);
    read1 = sb[0].r1;
    read2 = sb[0].r2;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_chk++;
      if (res_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stale_done_capture: got res_valid=%0b at cycle %0d, expected 0", res_valid, i);
      end
    end
    done = 1'b0;
    cyc();
    done     = 1'b1;
    done_cyc = cyc_n;
    drain(10);
    done = 1'b0;
    cyc();
  endtask

  task automatic test_watchdog();
    bit acc;
    model_en = 1'b0;
    done     = 1'b0;
`ifdef PROCESS_ISSUER_WATCHDOG_EN
    begin
      int i;
      push(3'b101, 5'd3, 5'd4, 5'd7, 16'sd11, acc);
      push(3'b001, 5'd1, 5'd0, 5'd8, 16'sd12, acc);
      i = 0;
      while (err_timeout !== 1'b1 && i < 30) begin
        cyc();
        n_chk++;
        if (res_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL watchdog_no_result: got res_valid=1, expected 0");
        end
        i++;
      end
      n_chk++;
      if (err_timeout !== 1'b1) begin
        n_fail++;
        $display("FAIL watchdog_err: got %0b, expected 1", err_timeout);
      end
      void'(sb.pop_front());
      i = 0;
      while (instruction !== 3'b001 && i < 5) begin
        cyc();
        i++;
      end
      n_chk++;
      if (instruction !== 3'b001) begin
        n_fail++;
        $display("FAIL watchdog_next_issue: got %0b, expected 001", instruction);
      end
      model_en = 1'b1;
      mdl_cnt  = 2;
      drain(30);
      model_en = 1'b0;
      push(3'b101, 5'd3, 5'd4, 5'd7, 16'sd11, acc);
      for (int k = 0; k < 5; k++) cyc();
    end
`else
    push(3'b101, 5'd3, 5'd4, 5'd7, 16'sd11, acc);
    for (int i = 0; i < 40; i++) begin
      cyc();
      n_chk++;
      if (res_valid !== 1'b0 || err_timeout !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL permanent_wait: got v=%0b err=%0b busy=%0b, expected 0 0 1", res_valid, err_timeout, busy);
      end
    end
    n_chk++;
    if (instruction !== 3'b101 || write_adr !== 5'd7 || data !== 16'sd11) begin
      n_fail++;
      $display("FAIL wait_operands_held: got op=%0b wadr=%0d d=%0d, expected 101 7 11", instruction, write_adr, data);
    end
`endif
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sb.delete();
    n_chk++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || err_timeout !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midwait_reset_ctrl: got ready=%0b busy=%0b err=%0b v=%0b, expected 1 0 0 0",
               cmd_ready, busy, err_timeout, res_valid);
    end
    n_chk++;
    if ({instruction, input_adr1, input_adr2, write_adr, data, res_op, res_val1, res_val2} !== '0) begin
      n_fail++;
      $display("FAIL midwait_reset_outputs: got op=%0b a1=%0d a2=%0d wa=%0d d=%0d rop=%0b v1=%0d v2=%0d, expected all 0",
               instruction, input_adr1, input_adr2, write_adr, data, res_op, res_val1, res_val2);
    end
    for (int i = 0; i < 3; i++) cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    n_chk = 0; n_fail = 0; cyc_n = 0; done_cyc = 0; mdl_cnt = 0; mdl_lat = 5;
    model_en = 1'b0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_adr1 = '0; cmd_adr2 = '0; cmd_wadr = '0;
    cmd_data = '0; done = 1'b0; read1 = '0; read2 = '0;
    foreach (rf[i]) rf[i] = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_long_op();
    test_fifo_full();
    test_stale_done();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
